// File: rtl/spi_pkg.sv
// Shared types and edge-classification helpers for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_WORD_SIZE_W = 5;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_t;

  // Leading edge leaves the CPOL idle level, trailing edge returns to it.
  function automatic logic is_sample_edge(spi_mode_t mode, logic rise, logic fall);
    logic leading;
    logic trailing;
    leading  = mode.cpol ? fall : rise;
    trailing = mode.cpol ? rise : fall;
    return mode.cpha ? trailing : leading;
  endfunction

  function automatic logic is_shift_edge(spi_mode_t mode, logic rise, logic fall);
    logic leading;
    logic trailing;
    leading  = mode.cpol ? fall : rise;
    trailing = mode.cpol ? rise : fall;
    return mode.cpha ? leading : trailing;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Local-side tx/rx holding-register handshakes of the SPI slave.
interface spi_slave_if #(
  parameter int unsigned MAX_WORD_SIZE = 32
);
  logic [MAX_WORD_SIZE-1:0] txData;
  logic                     txValid;
  logic                     txReady;
  logic [MAX_WORD_SIZE-1:0] rxData;
  logic                     rxValid;
  logic                     rxReady;

  modport slave (
    input  txData, txValid, rxReady,
    output txReady, rxData, rxValid
  );

  modport master (
    output txData, txValid, rxReady,
    input  txReady, rxData, rxValid
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall detection.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stages <= {SYNC_STAGES{RESET_VALUE}};
      prev   <= RESET_VALUE;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pin};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign level = stages[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled pins, all CPOL/CPHA modes, 1..MAX_WORD_SIZE bit words.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned MAX_WORD_SIZE = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sclkPolarity,
  input  logic                       sclkPhase,
  input  logic [SPI_WORD_SIZE_W-1:0] wordSize,
  spi_slave_if.slave                 bus,
  output logic                       busy,
  output logic                       txUnderrun,
  output logic                       rxOverrun,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic                       misoOe
);

  logic ncs_level, ncs_fall, ncs_rise_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_ncs_sync (
    .clock(clock), .reset(reset), .pin(nCS),
    .level(ncs_level), .rise(ncs_rise_unused), .fall(ncs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sclk_sync (
    .clock(clock), .reset(reset), .pin(SCLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_mosi_sync (
    .clock(clock), .reset(reset), .pin(MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t state_q, state_d;

  spi_mode_t                  mode_q;
  logic [SPI_WORD_SIZE_W-1:0] ws_q;
  logic [SPI_WORD_SIZE_W-1:0] bit_cnt;
  logic [MAX_WORD_SIZE-1:0]   tx_shift;
  logic [MAX_WORD_SIZE-1:0]   hold;
  logic [MAX_WORD_SIZE-1:0]   rx_shift;
  logic [MAX_WORD_SIZE-1:0]   rx_next;
  logic [MAX_WORD_SIZE-1:0]   rx_word;
  logic [MAX_WORD_SIZE-1:0]   word_mask;
  logic [MAX_WORD_SIZE-1:0]   rx_data_q;
  logic                       rx_valid_q;
  logic                       hold_full;
  logic                       skip_shift;
  logic                       frame_start, active_run;
  logic                       sample_edge, shift_edge, word_done;
  logic                       tx_load, tx_write;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ncs_fall && enable) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ncs_level || !enable) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_ACTIVE);
    misoOe      = busy;
    bus.txReady = !hold_full;
  end

  // Edges coinciding with frame exit are dropped so an abort leaves no trace.
  assign frame_start = (state_q == ST_IDLE) && (state_d == ST_ACTIVE);
  assign active_run  = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);
  assign sample_edge = active_run && is_sample_edge(mode_q, sclk_rise, sclk_fall);
  assign shift_edge  = active_run && is_shift_edge(mode_q, sclk_rise, sclk_fall);
  assign word_done   = sample_edge && (bit_cnt == ws_q);
  assign tx_load     = frame_start || word_done;
  assign tx_write    = bus.txValid && !hold_full;

  always_comb begin
    word_mask = '0;
    for (int unsigned i = 0; i < MAX_WORD_SIZE; i++) word_mask[i] = (i <= 32'(ws_q));
  end

  assign rx_next     = (rx_shift << 1) | MAX_WORD_SIZE'(mosi_level);
  assign rx_word     = rx_next & word_mask;
  assign bus.rxData  = rx_data_q;
  assign bus.rxValid = rx_valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q     <= '0;
      ws_q       <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      skip_shift <= 1'b0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      txUnderrun <= 1'b0;
      rxOverrun  <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      txUnderrun <= 1'b0;
      rxOverrun  <= 1'b0;
      MISO       <= busy ? tx_shift[ws_q] : 1'b0;

      if (rx_valid_q && bus.rxReady) rx_valid_q <= 1'b0;

      if (frame_start) begin
        mode_q.cpol <= sclkPolarity;
        mode_q.cpha <= sclkPhase;
        ws_q        <= wordSize;
        bit_cnt     <= '0;
        rx_shift    <= '0;
      end else if (sample_edge) begin
        if (word_done) begin
          bit_cnt  <= '0;
          rx_shift <= '0;
          if (!rx_valid_q) begin
            rx_data_q  <= rx_word;
            rx_valid_q <= 1'b1;
          end else begin
            rxOverrun <= 1'b1;
          end
        end else begin
          bit_cnt  <= bit_cnt + 1'b1;
          rx_shift <= rx_next;
        end
      end

      // CPHA=0 frame start presents the MSB immediately; every other load
      // waits out the shift edge that would otherwise discard it.
      if (tx_load) begin
        tx_shift   <= hold_full ? hold : '0;
        txUnderrun <= !hold_full;
        hold_full  <= 1'b0;
        skip_shift <= frame_start ? sclkPhase : 1'b1;
      end else if (shift_edge) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx_shift   <= tx_shift << 1;
      end

      if (tx_write) begin
        hold      <= bus.txData;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: bit-banged SPI master plus local-side handshakes.
module tb_spi_slave;

  localparam int HP = 8;

  int checks = 0;
  int errors = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       sclkPolarity = 1'b0;
  logic       sclkPhase = 1'b0;
  logic [4:0] wordSize = 5'd7;
  logic       busy, txUnderrun, rxOverrun;
  logic       nCS = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO, misoOe;

  spi_slave_if #(.MAX_WORD_SIZE(32)) bus ();

  spi_slave #(.MAX_WORD_SIZE(32), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .sclkPolarity(sclkPolarity), .sclkPhase(sclkPhase), .wordSize(wordSize),
    .bus(bus), .busy(busy), .txUnderrun(txUnderrun), .rxOverrun(rxOverrun),
    .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .misoOe(misoOe)
  );

  always #5 clock = ~clock;

  logic [31:0] rxq[$];
  int underruns = 0;
  int overruns  = 0;

  always @(negedge clock) begin
    if (bus.rxValid && bus.rxReady) rxq.push_back(bus.rxData);
    if (txUnderrun) underruns++;
    if (rxOverrun) overruns++;
  end

  function automatic logic [31:0] rx_at(int idx);
    if (idx < rxq.size()) return rxq[idx];
    return 32'hxxxxxxxx;
  endfunction

  task automatic set_rx_ready(input logic v);
    @(posedge clock);
    #1 bus.rxReady = v;
  endtask

  task automatic tx_write(input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    while (!bus.txReady && n < 5000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.txReady !== 1'b1) begin
      errors++;
      $display("FAIL tx_write_wait txReady=%b required 1", bus.txReady);
    end
    bus.txData  = d;
    bus.txValid = 1'b1;
    @(negedge clock);
    bus.txValid = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy busy=%b required 1", busy);
    end
  endtask

  // Master side: MSB first, nbits total, abort after stop_after bits.
  task automatic spi_xfer(input int nbits, input logic [63:0] mo, input int stop_after,
                          output logic [63:0] mi);
    mi = '0;
    @(negedge clock);
    SCLK = sclkPolarity;
    MOSI = 1'b0;
    repeat (HP) @(negedge clock);
    nCS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == stop_after) break;
      if (!sclkPhase) begin
        MOSI = mo[nbits-1-i];
        repeat (HP) @(negedge clock);
        mi = {mi[62:0], MISO};
        SCLK = ~sclkPolarity;
        repeat (HP) @(negedge clock);
        SCLK = sclkPolarity;
      end else begin
        repeat (HP) @(negedge clock);
        SCLK = ~sclkPolarity;
        MOSI = mo[nbits-1-i];
        repeat (HP) @(negedge clock);
        mi = {mi[62:0], MISO};
        SCLK = sclkPolarity;
      end
    end
    repeat (HP) @(negedge clock);
    nCS = 1'b1;
    repeat (2 * HP) @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({MISO, misoOe, busy, bus.txReady, bus.rxValid, txUnderrun, rxOverrun} !== 7'b0001000) begin
      errors++;
      $display("FAIL %s_flags {MISO,misoOe,busy,txReady,rxValid,txUnderrun,rxOverrun}=%b required 0001000",
               tag, {MISO, misoOe, busy, bus.txReady, bus.rxValid, txUnderrun, rxOverrun});
    end
    checks++;
    if (bus.rxData !== 32'h0) begin
      errors++;
      $display("FAIL %s_rxData got %h required 00000000", tag, bus.rxData);
    end
  endtask

  task automatic test_reset();
    bus.txData  = '0;
    bus.txValid = 1'b0;
    bus.rxReady = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("post_reset");
  endtask

  task automatic test_mode0();
    logic [63:0] mi;
    int base;
    sclkPolarity = 1'b0;
    sclkPhase    = 1'b0;
    wordSize     = 5'd15;
    tx_write(32'h0000A5C3);
    base = rxq.size();
    spi_xfer(16, 64'h1234, 64, mi);
    checks++;
    if (rxq.size() != base + 1 || rx_at(base) !== 32'h00001234) begin
      errors++;
      $display("FAIL mode0_rx got %h (words %0d) required 00001234 (1)", rx_at(base), rxq.size() - base);
    end
    checks++;
    if (mi[15:0] !== 16'hA5C3) begin
      errors++;
      $display("FAIL mode0_miso got %h required a5c3", mi[15:0]);
    end
    checks++;
    if (busy !== 1'b0 || bus.rxValid !== 1'b0) begin
      errors++;
      $display("FAIL mode0_idle busy=%b rxValid=%b required 0 0", busy, bus.rxValid);
    end
  endtask

  task automatic test_modes();
    logic [63:0] mi;
    int base;
    logic [1:0] m;
    for (int k = 1; k <= 3; k++) begin
      m = 2'(k);
      sclkPolarity = m[1];
      sclkPhase    = m[0];
      wordSize     = 5'd7;
      tx_write(32'h5A);
      base = rxq.size();
      spi_xfer(8, 64'hC3, 64, mi);
      checks++;
      if (rxq.size() != base + 1 || rx_at(base) !== 32'h000000C3) begin
        errors++;
        $display("FAIL mode%0d_rx got %h required 000000c3", k, rx_at(base));
      end
      checks++;
      if (mi[7:0] !== 8'h5A) begin
        errors++;
        $display("FAIL mode%0d_miso got %h required 5a", k, mi[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] mi;
    int base, u0, o0;
    sclkPolarity = 1'b1;
    sclkPhase    = 1'b1;
    wordSize     = 5'd31;
    tx_write(32'hDEADBEEF);
    base = rxq.size();
    u0 = underruns;
    o0 = overruns;
    fork
      spi_xfer(64, 64'h89ABCDEF_13579BDF, 64, mi);
      begin
        tx_write(32'h01234567);
        tx_write(32'h00000000);
      end
    join
    checks++;
    if (rx_at(base) !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL b2b_rx0 got %h required 89abcdef", rx_at(base));
    end
    checks++;
    if (rxq.size() != base + 2 || rx_at(base + 1) !== 32'h13579BDF) begin
      errors++;
      $display("FAIL b2b_rx1 got %h required 13579bdf", rx_at(base + 1));
    end
    checks++;
    if (mi !== 64'hDEADBEEF_01234567) begin
      errors++;
      $display("FAIL b2b_miso got %h required deadbeef01234567", mi);
    end
    checks++;
    if (underruns != u0 || overruns != o0) begin
      errors++;
      $display("FAIL b2b_flags underruns=%0d overruns=%0d required 0 0", underruns - u0, overruns - o0);
    end
  endtask

  task automatic test_underrun_overrun();
    logic [63:0] mi;
    int base, u0, o0;
    sclkPolarity = 1'b0;
    sclkPhase    = 1'b0;
    wordSize     = 5'd7;
    set_rx_ready(1'b0);
    base = rxq.size();
    u0 = underruns;
    o0 = overruns;
    fork
      spi_xfer(16, 64'hA73B, 64, mi);
      begin
        wait_busy();
        tx_write(32'h3C);
        tx_write(32'h00);
      end
    join
    checks++;
    if (mi[15:0] !== 16'h003C) begin
      errors++;
      $display("FAIL uo_miso got %h required 003c", mi[15:0]);
    end
    checks++;
    if (underruns - u0 != 1) begin
      errors++;
      $display("FAIL uo_underrun_count got %0d required 1", underruns - u0);
    end
    checks++;
    if (overruns - o0 != 1) begin
      errors++;
      $display("FAIL uo_overrun_count got %0d required 1", overruns - o0);
    end
    checks++;
    if (bus.rxValid !== 1'b1 || bus.rxData !== 32'h000000A7) begin
      errors++;
      $display("FAIL uo_held rxValid=%b rxData=%h required 1 000000a7", bus.rxValid, bus.rxData);
    end
    set_rx_ready(1'b1);
    repeat (4) @(negedge clock);
    checks++;
    if (rxq.size() != base + 1 || rx_at(base) !== 32'h000000A7 || bus.rxValid !== 1'b0) begin
      errors++;
      $display("FAIL uo_drain got %h words %0d rxValid=%b required 000000a7 1 0",
               rx_at(base), rxq.size() - base, bus.rxValid);
    end
  endtask

  task automatic test_abort();
    logic [63:0] mi;
    int base, o0;
    sclkPolarity = 1'b0;
    sclkPhase    = 1'b0;
    wordSize     = 5'd15;
    base = rxq.size();
    o0 = overruns;
    spi_xfer(16, 64'h0000, 5, mi);
    checks++;
    if (rxq.size() != base || bus.rxValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state words=%0d rxValid=%b busy=%b required 0 0 0",
               rxq.size() - base, bus.rxValid, busy);
    end
    checks++;
    if (overruns != o0) begin
      errors++;
      $display("FAIL abort_overrun got %0d required 0", overruns - o0);
    end
    spi_xfer(16, 64'hFFFF, 64, mi);
    checks++;
    if (rxq.size() != base + 1 || rx_at(base) !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL abort_next_rx got %h words %0d required 0000ffff 1", rx_at(base), rxq.size() - base);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] mi;
    int base;
    sclkPolarity = 1'b0;
    sclkPhase    = 1'b0;
    wordSize     = 5'd7;
    set_rx_ready(1'b0);
    spi_xfer(8, 64'h5E, 64, mi);
    checks++;
    if (bus.rxValid !== 1'b1 || bus.rxData !== 32'h5E) begin
      errors++;
      $display("FAIL ar_pre rxValid=%b rxData=%h required 1 0000005e", bus.rxValid, bus.rxData);
    end
    tx_write(32'h77);
    @(negedge clock);
    nCS  = 1'b0;
    MOSI = 1'b1;
    wait_busy();
    tx_write(32'h11);
    repeat (HP) @(negedge clock);
    SCLK = 1'b1;
    repeat (HP) @(negedge clock);
    SCLK = 1'b0;
    repeat (HP) @(negedge clock);
    reset = 1'b0;
    nCS   = 1'b1;
    #1;
    check_reset_values("ar_mid");
    @(negedge clock);
    reset = 1'b1;
    set_rx_ready(1'b1);
    tx_write(32'h96);
    base = rxq.size();
    spi_xfer(8, 64'h69, 64, mi);
    checks++;
    if (rxq.size() != base + 1 || rx_at(base) !== 32'h69) begin
      errors++;
      $display("FAIL ar_next_rx got %h words %0d required 00000069 1", rx_at(base), rxq.size() - base);
    end
    checks++;
    if (mi[7:0] !== 8'h96) begin
      errors++;
      $display("FAIL ar_next_miso got %h required 96", mi[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_underrun_overrun();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
